// File: rtl/sync_trial_pkg.sv
// rtl/sync_trial_pkg.sv - shared types and helpers for the synchronizer trial sequencer
package sync_trial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int ARM_CYCLES = 2;

  function automatic logic [3:0] gray_encode(input logic [3:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/toggle_sync_rx.sv
// rtl/toggle_sync_rx.sv - two-flop toggle synchronizer with registered edge pulse
module toggle_sync_rx (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl,
  output logic ev_pulse
);

  logic s1;
  logic s2;
  logic s3;

  // Resynchronize the toggle and flag any change as a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      ev_pulse <= 1'b0;
    end else begin
      s1       <= tgl;
      s2       <= s1;
      s3       <= s2;
      ev_pulse <= s2 ^ s3;
    end
  end

endmodule

// File: rtl/sync_trial_controller.sv
// rtl/sync_trial_controller.sv - trial sequencer: source counter, history window, sample checker
module sync_trial_controller
  import sync_trial_pkg::*;
#(
  parameter int LEN_W        = 16,
  parameter int CNT_W        = 16,
  parameter int HIST_DEPTH   = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             gray_mode,
  input  logic [LEN_W-1:0] trial_len,
  input  logic [3:0]       sample_data,
  input  logic             sample_tgl,
  output logic [3:0]       src_count,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int TMR_W = (LEN_W > DRN_W) ? LEN_W : DRN_W;

  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] tmr;
  logic [LEN_W-1:0] len_q;
  logic             gray_q;
  logic [3:0]       bin;
  logic [3:0]       bin_inc;
  logic [3:0]       src_next;
  logic [3:0]       hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld;
  logic [3:0]       data_q;
  logic [3:0]       chk_data;
  logic             chk_valid;
  logic             ev;
  logic             hit;
  logic             arm_first;
  logic             advance;
  logic             in_check;

  toggle_sync_rx u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgl      (sample_tgl),
    .ev_pulse (ev)
  );

  assign busy      = (state == S_ARM) || (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign in_check  = (state == S_RUN) || (state == S_DRAIN);
  assign arm_first = (state == S_ARM) && (tmr == '0);
  assign advance   = (state_next == S_RUN);
  assign bin_inc   = bin + 4'd1;
  assign src_next  = gray_q ? gray_encode(bin_inc) : bin_inc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_ARM;
      S_ARM:   if (tmr == TMR_W'(ARM_CYCLES - 1))
                 state_next = (len_q == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (tmr == TMR_W'(len_q - LEN_W'(1))) state_next = S_DRAIN;
      S_DRAIN: if (tmr == TMR_W'(DRAIN_CYCLES - 1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  // Per-state cycle timer, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if ((state_next != state) || (state == S_IDLE)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  // Source counter and history: cleared on ARM entry, stepped on each cycle heading into RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q    <= 1'b0;
      len_q     <= '0;
      bin       <= 4'd0;
      src_count <= 4'd0;
      hist_vld  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= 4'd0;
    end else begin
      if (arm_first) begin
        gray_q    <= gray_mode;
        len_q     <= trial_len;
        bin       <= 4'd0;
        src_count <= 4'd0;
        hist_vld  <= '0;
      end
      if (advance) begin
        bin         <= bin_inc;
        src_count   <= src_next;
        hist[0]     <= src_next;
        hist_vld[0] <= 1'b1;
        for (int i = HIST_DEPTH - 1; i > 0; i--) begin
          hist[i]     <= hist[i-1];
          hist_vld[i] <= hist_vld[i-1];
        end
      end
    end
  end

  // Parallel compare of the pending sample against every valid history entry.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (hist_vld[i] && (hist[i] == chk_data)) hit = 1'b1;
    end
  end

  // Sample capture and saturating counters; the one-cycle-old data copy has settled by event time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= 4'd0;
      chk_data     <= 4'd0;
      chk_valid    <= 1'b0;
      sample_count <= '0;
      err_count    <= '0;
    end else begin
      data_q    <= sample_data;
      chk_valid <= ev && in_check;
      if (ev) chk_data <= data_q;
      if (state == S_ARM) begin
        sample_count <= '0;
        err_count    <= '0;
      end else if (chk_valid) begin
        if (sample_count != '1) sample_count <= sample_count + CNT_W'(1);
        if (!hit && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_trial_controller.sv
// tb/tb_sync_trial_controller.sv - self-checking bench for sync_trial_controller
module tb_sync_trial_controller;

  localparam int LEN_W = 16;
  localparam int CNT_W = 16;
  localparam int H     = 8;
  localparam int D     = 8;
  localparam int D2    = 120;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             gray_mode = 1'b0;
  logic [LEN_W-1:0] trial_len = '0;
  logic [3:0]       sample_data = 4'd0;
  logic             sample_tgl = 1'b0;
  logic [3:0]       src_count;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;

  logic             start2 = 1'b0;
  logic             abort2 = 1'b0;
  logic             gray2 = 1'b0;
  logic [LEN_W-1:0] len2 = '0;
  logic [3:0]       data2 = 4'd0;
  logic             tgl2 = 1'b0;
  logic [3:0]       src2;
  logic             busy2;
  logic             done2;
  logic [3:0]       scnt2;
  logic [3:0]       ecnt2;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] exp_prev_src = 4'd0;
  int         exp_s;
  int         exp_e;
  int         obs_busy_cycles;
  int         obs_done_cycle;
  int         done_pulses;
  logic [3:0] seq_q [$];

  always #5 clk = ~clk;

  sync_trial_controller #(.LEN_W(LEN_W), .CNT_W(CNT_W), .HIST_DEPTH(H), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gray_mode(gray_mode),
    .trial_len(trial_len), .sample_data(sample_data), .sample_tgl(sample_tgl),
    .src_count(src_count), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count)
  );

  sync_trial_controller #(.LEN_W(LEN_W), .CNT_W(4), .HIST_DEPTH(H), .DRAIN_CYCLES(D2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .gray_mode(gray2),
    .trial_len(len2), .sample_data(data2), .sample_tgl(tgl2),
    .src_count(src2), .busy(busy2), .done(done2),
    .sample_count(scnt2), .err_count(ecnt2)
  );

  // Reference model, in cycles relative to the cycle holding start (cycle 0).
  // Values pushed so far by cycle x: one per cycle from cycle 3, capped at L, frozen by abort.
  function automatic int f_n(int x, int L, int a);
    int m;
    m = (a >= 0 && x > a) ? a : x;
    m = m - 2;
    if (m < 0) m = 0;
    if (m > L) m = L;
    return m;
  endfunction

  function automatic logic [3:0] f_enc(int k, bit g);
    logic [3:0] b;
    b = 4'(k % 16);
    return g ? (b ^ (b >> 1)) : b;
  endfunction

  function automatic bit f_window(int e, int L, int a);
    return (e >= 3) && (e <= 2 + L + D) && (a < 0 || e <= a);
  endfunction

  function automatic bit f_in_hist(int x, int L, int a, bit g, logic [3:0] v);
    int n;
    n = f_n(x, L, a);
    for (int k = n; k >= 1 && k > n - H; k--) if (f_enc(k, g) == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_trial(input int L, input bit g, input int first, input int spacing,
                             input int last, input bit rand_vals, input int inj_x,
                             input logic [3:0] inj_v, input int a, input int restart_x);
    int         total;
    logic [3:0] v;
    logic [3:0] exp_src;
    logic       exp_busy;
    logic       exp_done;
    total = 3 + L + D + 2;
    if (last + 8 > total) total = last + 8;
    exp_s = 0; exp_e = 0; obs_busy_cycles = 0; obs_done_cycle = -1; done_pulses = 0;
    seq_q.delete();
    gray_mode = g;
    trial_len = LEN_W'(L);
    start = 1'b1;
    for (int x = 1; x <= total; x++) begin
      @(posedge clk); #1;
      start = (x == restart_x);
      abort = (x == a);
      if (x >= 2) begin
        gray_mode = 1'($urandom);
        trial_len = LEN_W'($urandom);
      end
      exp_busy = (x <= 2 + L + D) && (a < 0 || x <= a);
      exp_done = (x == 3 + L + D) && (a < 0);
      exp_src  = (x < 2) ? exp_prev_src : f_enc(f_n(x, L, a), g);
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy cycle %0d: got %b expected %b", x, busy, exp_busy);
      end
      n_checks++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL done cycle %0d: got %b expected %b", x, done, exp_done);
      end
      n_checks++;
      if (src_count !== exp_src) begin
        n_fail++;
        $display("FAIL src_count cycle %0d: got %h expected %h", x, src_count, exp_src);
      end
      if (busy === 1'b1) obs_busy_cycles++;
      if (done === 1'b1) begin
        done_pulses++;
        obs_done_cycle = x;
      end
      if (x >= 2 && (seq_q.size() == 0 || seq_q[$] !== src_count)) seq_q.push_back(src_count);
      if (x >= first && x <= last && ((x - first) % spacing) == 0) begin
        v = f_enc(f_n(x, L, a), g);
        if (rand_vals) v = 4'($urandom);
        if (x == inj_x) v = inj_v;
        sample_data = v;
        sample_tgl  = ~sample_tgl;
        if (f_window(x + 3, L, a)) begin
          exp_s++;
          if (!f_in_hist(x + 4, L, a, g, v)) exp_e++;
        end
      end
    end
    start = 1'b0;
    abort = 1'b0;
    exp_prev_src = f_enc(f_n(total, L, a), g);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (src_count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got src=%h busy=%b done=%b expected 0/0/0", src_count, busy, done);
    end
    n_checks++;
    if (sample_count !== '0 || err_count !== '0) begin
      n_fail++;
      $display("FAIL reset counters: got %0d/%0d expected 0/0", sample_count, err_count);
    end
    n_checks++;
    if (src2 !== 4'd0 || busy2 !== 1'b0 || done2 !== 1'b0 || scnt2 !== 4'd0 || ecnt2 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset sat instance: got src=%h busy=%b done=%b cnt=%0d/%0d expected zeros",
               src2, busy2, done2, scnt2, ecnt2);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string name);
    n_checks++;
    if (sample_count !== CNT_W'(exp_s)) begin
      n_fail++;
      $display("FAIL %s sample_count: got %0d expected %0d", name, sample_count, exp_s);
    end
    n_checks++;
    if (err_count !== CNT_W'(exp_e)) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_e);
    end
  endtask

  task automatic test_binary_echo;
    drive_trial(20, 1'b0, 3, 3, 21, 1'b0, -1, 4'd0, -1, -1);
    check_counts("binary_echo");
    n_checks++;
    if (obs_busy_cycles != 2 + 20 + D || obs_done_cycle != 3 + 20 + D || done_pulses != 1) begin
      n_fail++;
      $display("FAIL binary_echo timing: got busy=%0d done_at=%0d pulses=%0d expected %0d/%0d/1",
               obs_busy_cycles, obs_done_cycle, done_pulses, 2 + 20 + D, 3 + 20 + D);
    end
  endtask

  task automatic test_inject_error;
    drive_trial(20, 1'b0, 3, 3, 21, 1'b0, 6, 4'hF, -1, -1);
    check_counts("inject_error");
  endtask

  task automatic test_gray;
    logic [3:0] want [7] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5};
    drive_trial(6, 1'b1, 3, 3, 9, 1'b0, -1, 4'd0, -1, -1);
    check_counts("gray");
    n_checks++;
    if (seq_q.size() != 7) begin
      n_fail++;
      $display("FAIL gray sequence length: got %0d expected 7", seq_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (seq_q[i] !== want[i]) begin
          n_fail++;
          $display("FAIL gray sequence[%0d]: got %h expected %h", i, seq_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len;
    drive_trial(0, 1'b0, 2, 3, 8, 1'b0, -1, 4'd0, -1, -1);
    check_counts("zero_len");
    n_checks++;
    if (obs_busy_cycles != 2 + D || seq_q.size() != 1 || seq_q[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL zero_len: got busy=%0d distinct_src=%0d expected %0d cycles, src held 0",
               obs_busy_cycles, seq_q.size(), 2 + D);
    end
  endtask

  task automatic test_drain_edges;
    drive_trial(4, 1'b0, 4 + D - 1, 3, 4 + D - 1, 1'b0, -1, 4'd0, -1, -1);
    check_counts("drain_last_cycle");
    drive_trial(4, 1'b0, 4 + D, 3, 4 + D, 1'b0, -1, 4'd0, -1, -1);
    check_counts("done_cycle_event");
    drive_trial(4, 1'b1, 3, 3, 3, 1'b0, 3, f_enc(4, 1'b1), -1, -1);
    check_counts("run_to_drain_event");
  endtask

  task automatic test_abort;
    drive_trial(20, 1'b0, 1, 3, 7, 1'b0, -1, 4'd0, 7, 4);
    check_counts("abort");
    n_checks++;
    if (done_pulses != 0 || obs_busy_cycles != 7) begin
      n_fail++;
      $display("FAIL abort: got done_pulses=%0d busy=%0d expected 0/7", done_pulses, obs_busy_cycles);
    end
    n_checks++;
    if (src_count !== f_enc(5, 1'b0)) begin
      n_fail++;
      $display("FAIL abort frozen src: got %h expected %h", src_count, f_enc(5, 1'b0));
    end
  endtask

  task automatic test_reset_mid_run;
    gray_mode = 1'b0;
    trial_len = LEN_W'(30);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (src_count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        sample_count !== '0 || err_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got src=%h busy=%b done=%b cnt=%0d/%0d expected zeros",
               src_count, busy, done, sample_count, err_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_prev_src = 4'd0;
    @(posedge clk); #1;
    drive_trial(10, 1'b1, 3, 4, 20, 1'b1, -1, 4'd0, -1, -1);
    check_counts("after_reset");
    n_checks++;
    if (done_pulses != 1 || obs_done_cycle != 3 + 10 + D) begin
      n_fail++;
      $display("FAIL after_reset done: got pulses=%0d at %0d expected 1 at %0d",
               done_pulses, obs_done_cycle, 3 + 10 + D);
    end
  endtask

  task automatic test_random;
    int L;
    int sp;
    int fi;
    for (int t = 0; t < 6; t++) begin
      L  = int'($urandom_range(1, 30));
      sp = int'($urandom_range(3, 6));
      fi = int'($urandom_range(1, 5));
      drive_trial(L, 1'($urandom), fi, sp, L + D + 2, 1'($urandom), -1, 4'd0, -1, -1);
      check_counts("random");
      n_checks++;
      if (done_pulses != 1 || obs_busy_cycles != 2 + L + D) begin
        n_fail++;
        $display("FAIL random L=%0d: got pulses=%0d busy=%0d expected 1/%0d",
                 L, done_pulses, obs_busy_cycles, 2 + L + D);
      end
    end
  endtask

  task automatic test_saturation;
    int exp_sat;
    int n_done;
    exp_sat = 0;
    n_done = 0;
    len2 = LEN_W'(3);
    gray2 = 1'b0;
    start2 = 1'b1;
    for (int x = 1; x <= 3 + 3 + D2 + 4; x++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (x >= 10 && x < 90 && ((x - 10) % 4) == 0) begin
        data2 = 4'hF;
        tgl2  = ~tgl2;
        if (exp_sat < 15) exp_sat++;
      end
      if (done2 === 1'b1) n_done++;
    end
    n_checks++;
    if (ecnt2 !== 4'(exp_sat) || scnt2 !== 4'(exp_sat)) begin
      n_fail++;
      $display("FAIL saturation: got samples=%0d errors=%0d expected %0d/%0d", scnt2, ecnt2, exp_sat, exp_sat);
    end
    n_checks++;
    if (n_done != 1 || src2 !== 4'd3) begin
      n_fail++;
      $display("FAIL saturation trial: got done_pulses=%0d src=%h expected 1/3", n_done, src2);
    end
  endtask

  initial begin
    test_reset;
    test_binary_echo;
    test_inject_error;
    test_gray;
    test_zero_len;
    test_drain_edges;
    test_abort;
    test_reset_mid_run;
    test_random;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
